// File: rtl/seq_div_32_bit.sv
// Iterative unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
// Trial subtraction is formed as rem + ~divisor + 1, mirroring the adder datapath.
module seq_div_32_bit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state_q;
    logic [WIDTH-1:0]  rem_q;
    logic [WIDTH-1:0]  q_q;
    logic [WIDTH-1:0]  d_q;
    logic [CntW-1:0]   count_q;
    logic              busy_q;
    logic              done_q;
    logic              dbz_q;
    logic [WIDTH-1:0]  quotient_q;
    logic [WIDTH-1:0]  remainder_q;

    logic [WIDTH:0]    rem_shift;
    logic [WIDTH:0]    trial;
    logic              borrow;
    logic [WIDTH-1:0]  rem_d;
    logic [WIDTH-1:0]  q_d;
    logic              accept;

    // The restored remainder is always below the divisor, so WIDTH bits of state suffice;
    // only the trial result needs the extra borrow bit.
    always_comb begin
        rem_shift = {rem_q, q_q[WIDTH-1]};
        trial     = rem_shift + {1'b1, ~d_q} + {{WIDTH{1'b0}}, 1'b1};
        borrow    = trial[WIDTH];
        if (!borrow) begin
            rem_d = trial[WIDTH-1:0];
        end else begin
            rem_d = rem_shift[WIDTH-1:0];
        end
        q_d    = {q_q[WIDTH-2:0], ~borrow};
        accept = start_i && (state_q != StRun);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            rem_q       <= '0;
            q_q         <= '0;
            d_q         <= '0;
            count_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (accept) begin
                        rem_q   <= '0;
                        q_q     <= dividend_i;
                        d_q     <= divisor_i;
                        count_q <= CntW'(WIDTH);
                        if (divisor_i == '0) begin
                            state_q     <= StDone;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            dbz_q       <= 1'b1;
                            quotient_q  <= '1;
                            remainder_q <= dividend_i;
                        end else begin
                            state_q <= StRun;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                StRun: begin
                    rem_q   <= rem_d;
                    q_q     <= q_d;
                    count_q <= count_q - 1'b1;
                    if (count_q == CntW'(1)) begin
                        state_q     <= StDone;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        dbz_q       <= 1'b0;
                        quotient_q  <= q_d;
                        remainder_q <= rem_d;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign quotient_o    = quotient_q;
    assign remainder_o   = remainder_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_seq_div_32_bit.sv
// Scoreboard bench for seq_div_32_bit: expected results queued at start, checked on done.
module tb_seq_div_32_bit;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    seq_div_32_bit #(.WIDTH(W)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .dividend_i   (dividend),
        .divisor_i    (divisor),
        .busy_o       (busy),
        .done_o       (done),
        .quotient_o   (quotient),
        .remainder_o  (remainder),
        .div_by_zero_o(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
        end else begin
            e.q   = a / b;
            e.r   = a % b;
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Result monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done) begin
            check("busy_with_done", {31'd0, busy}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", quotient, e.q);
                check("remainder", remainder, e.r);
                check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
            end
        end
    end

    // Drives one operation from idle and waits for done; returns with the clock at the
    // falling edge of the done cycle.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
        int lat;
        int exp_lat;
        exp_lat = (b == '0) ? 1 : W + 1;
        sb.push_back(model(a, b));
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        lat = 1;
        if (b != '0) check("busy_after_start", {31'd0, busy}, 32'd1);
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, exp_lat);
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [W-1:0] a;
        logic [W-1:0] b;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_quotient", quotient, 32'd0);
        check("rst_remainder", remainder, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op(32'd100, 32'd7);
        do_op(32'hFFFF_FFFF, 32'd1);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(32'd3, 32'd10);
        do_op(32'd0, 32'd5);
        do_op(32'd5, 32'd0);
        do_op(32'd9, 32'd3);

        // Start while running is ignored; start in the done cycle is accepted back-to-back.
        sb.push_back(model(32'd100, 32'd7));
        @(negedge clk);
        start = 1'b1; dividend = 32'd100; divisor = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        start = 1'b1; dividend = 32'd50; divisor = 32'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        check("ignored_start_latency", cyc + 10, 33);
        sb.push_back(model(32'd50, 32'd5));
        start = 1'b1; dividend = 32'd50; divisor = 32'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        check("b2b_latency", cyc + 1, 33);

        // Mid-operation reset: outputs clear at once and the aborted op never completes.
        @(negedge clk);
        start = 1'b1; dividend = 32'd100; divisor = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_quotient", quotient, 32'd0);
        check("abort_remainder", remainder, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        do_op(32'd20, 32'd6);

        for (int i = 0; i < 200; i++) begin
            a = $urandom;
            if (i % 2 == 0) begin
                b = $urandom >> $urandom_range(0, 31);
                if (b == '0) b = 32'd1;
            end else begin
                b = $urandom_range(0, 15);
            end
            do_op(a, b);
        end

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
